// File: rtl/div_share_ctrl_pkg.sv
// Shared types and constants for the divider-sharing controller.
// State encoding, divide-by-zero result and parameter defaults.
package div_share_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCEPT  = 2'd1,
      ISSUE   = 2'd2,
      RESPOND = 2'd3
   } state_e;

   localparam int DEF_NUM_REQ = 2;
   localparam int DEF_WIDTH   = 16;
   localparam int DEF_TIMEOUT = 32;

   localparam int MAX_WIDTH = 64;
   localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = '1;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/div_share_ctrl_if.sv
// Bundle of requester, response and divider channels.
// The controller uses slave; its environment uses master.
interface div_share_ctrl_if
   import div_share_ctrl_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH
);

   logic [NUM_REQ*WIDTH-1:0] req_dividend;
   logic [NUM_REQ*WIDTH-1:0] req_divisor;
   logic [NUM_REQ-1:0]       req_stb;
   logic [NUM_REQ-1:0]       req_ack;

   logic [WIDTH-1:0]         rsp_quotient;
   logic [WIDTH-1:0]         rsp_modulo;
   logic                     rsp_err;
   logic [NUM_REQ-1:0]       rsp_stb;
   logic [NUM_REQ-1:0]       rsp_ack;

   logic [WIDTH-1:0]         div_dividend;
   logic [WIDTH-1:0]         div_divisor;
   logic                     div_stb;
   logic                     div_ack;
   logic [WIDTH-1:0]         div_quotient;
   logic [WIDTH-1:0]         div_modulo;

   logic                     busy;

   modport slave (
      input  req_dividend, req_divisor, req_stb,
      output req_ack,
      output rsp_quotient, rsp_modulo, rsp_err, rsp_stb,
      input  rsp_ack,
      output div_dividend, div_divisor, div_stb,
      input  div_ack, div_quotient, div_modulo,
      output busy
   );

   modport master (
      output req_dividend, req_divisor, req_stb,
      input  req_ack,
      input  rsp_quotient, rsp_modulo, rsp_err, rsp_stb,
      output rsp_ack,
      input  div_dividend, div_divisor, div_stb,
      output div_ack, div_quotient, div_modulo,
      input  busy
   );

endinterface

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first request after last_i,
// searching upward with wrap.
module div_share_ctrl_rr_arbiter
   import div_share_ctrl_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      last_i,
   output logic [IW-1:0]      grant_o,
   output logic               valid_o
);

   int          j_w;
   logic [IW-1:0] jj_w;

   // Walk from farthest to nearest so the nearest request wins.
   always_comb begin
      grant_o = last_i;
      valid_o = 1'b0;
      j_w     = 0;
      jj_w    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j_w = int'(last_i) + k;
         if (j_w >= NUM_REQ) j_w = j_w - NUM_REQ;
         jj_w = IW'(j_w);
         if (req_i[jj_w]) begin
            grant_o = jj_w;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one serial divider among NUM_REQ requesters, with
// round-robin grant, divide-by-zero guard and hang timeout.
module div_share_ctrl
   import div_share_ctrl_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   div_share_ctrl_if.slave  bus
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int CW = idx_w(TIMEOUT);

   state_e             state_q;
   logic [IW-1:0]      grant_q;
   logic [IW-1:0]      last_q;
   logic [NUM_REQ-1:0] req_ack_q;
   logic [NUM_REQ-1:0] rsp_stb_q;
   logic [WIDTH-1:0]   quot_q;
   logic [WIDTH-1:0]   mod_q;
   logic               err_q;
   logic [WIDTH-1:0]   dvd_q;
   logic [WIDTH-1:0]   dvs_q;
   logic               div_stb_q;
   logic               busy_q;
   logic [CW-1:0]      cnt_q;

   logic [IW-1:0]      gnt_d;
   logic               gnt_vld_d;
   logic [NUM_REQ-1:0] gnt_oh_d;
   logic [NUM_REQ-1:0] cur_oh;
   logic [WIDTH-1:0]   dvd_arr [NUM_REQ];
   logic [WIDTH-1:0]   dvs_arr [NUM_REQ];
   logic [WIDTH-1:0]   opa;
   logic [WIDTH-1:0]   opb;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_op
      assign dvd_arr[i] = bus.req_dividend[i*WIDTH +: WIDTH];
      assign dvs_arr[i] = bus.req_divisor[i*WIDTH +: WIDTH];
   end

   assign opa      = dvd_arr[grant_q];
   assign opb      = dvs_arr[grant_q];
   assign gnt_oh_d = NUM_REQ'(1) << gnt_d;
   assign cur_oh   = NUM_REQ'(1) << grant_q;

   div_share_ctrl_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_arb (
      .req_i   (bus.req_stb),
      .last_i  (last_q),
      .grant_o (gnt_d),
      .valid_o (gnt_vld_d)
   );

   // Sequencer: grant, issue to divider, return result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_q    <= IW'(NUM_REQ-1);
         req_ack_q <= '0;
         rsp_stb_q <= '0;
         quot_q    <= '0;
         mod_q     <= '0;
         err_q     <= 1'b0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         div_stb_q <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (gnt_vld_d) begin
                  grant_q   <= gnt_d;
                  req_ack_q <= gnt_oh_d;
                  busy_q    <= 1'b1;
                  state_q   <= ACCEPT;
               end
            end
            ACCEPT: begin
               req_ack_q <= '0;
               if (!bus.req_stb[grant_q]) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  dvd_q <= opa;
                  dvs_q <= opb;
                  if (opb == '0) begin
                     quot_q    <= DIV0_QUOT[WIDTH-1:0];
                     mod_q     <= opa;
                     err_q     <= 1'b1;
                     rsp_stb_q <= cur_oh;
                     state_q   <= RESPOND;
                  end else begin
                     div_stb_q <= 1'b1;
                     cnt_q     <= '0;
                     state_q   <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (bus.div_ack) begin
                  quot_q    <= bus.div_quotient;
                  mod_q     <= bus.div_modulo;
                  err_q     <= 1'b0;
                  div_stb_q <= 1'b0;
                  rsp_stb_q <= cur_oh;
                  state_q   <= RESPOND;
               end else if (cnt_q == CW'(TIMEOUT-1)) begin
                  quot_q    <= '0;
                  mod_q     <= '0;
                  err_q     <= 1'b1;
                  div_stb_q <= 1'b0;
                  rsp_stb_q <= cur_oh;
                  state_q   <= RESPOND;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESPOND: begin
               if (bus.rsp_ack[grant_q]) begin
                  rsp_stb_q <= '0;
                  last_q    <= grant_q;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ack      = req_ack_q;
   assign bus.rsp_stb      = rsp_stb_q;
   assign bus.rsp_quotient = quot_q;
   assign bus.rsp_modulo   = mod_q;
   assign bus.rsp_err      = err_q;
   assign bus.div_dividend = dvd_q;
   assign bus.div_divisor  = dvs_q;
   assign bus.div_stb      = div_stb_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural
// serial-divider model of configurable latency.
module tb_div_share_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   div_share_ctrl_if #(.NUM_REQ(2), .WIDTH(16)) bus ();

   div_share_ctrl #(
      .NUM_REQ (2),
      .WIDTH   (16),
      .TIMEOUT (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int lat      = 1;
   bit never    = 1'b0;

   bit                 running;
   int                 mcnt;
   logic signed [15:0] sa;
   logic signed [15:0] sb;

   // Divider model: ack after lat cycles of div_stb, or never.
   always @(negedge clk) begin
      if (rst) begin
         bus.div_ack = 1'b0;
         running     = 1'b0;
      end else if (bus.div_ack) begin
         bus.div_ack = 1'b0;
      end else begin
         if (!bus.div_stb) begin
            running = 1'b0;
         end else if (!running) begin
            running = 1'b1;
            mcnt    = 0;
            sa      = bus.div_dividend;
            sb      = bus.div_divisor;
         end
         if (running) begin
            mcnt++;
            if (!never && mcnt >= lat) begin
               bus.div_quotient = sa / sb;
               bus.div_modulo   = sa % sb;
               bus.div_ack      = 1'b1;
               running          = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int idx,
                         input logic [15:0] a,
                         input logic [15:0] b);
      bus.req_dividend[idx*16 +: 16] = a;
      bus.req_divisor[idx*16 +: 16]  = b;
   endtask

   task automatic wait_ack(input string tag, output int n);
      bit ok = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.req_ack != 0) begin
            ok = 1'b1;
            break;
         end
         tick();
         n++;
      end
      if (!ok) chk({tag, "_ack_to"}, 64'(ok), 64'd1);
   endtask

   task automatic wait_rsp(input string tag, output int n);
      bit ok = 1'b0;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         if (bus.rsp_stb != 0) begin
            ok = 1'b1;
            break;
         end
         tick();
         n++;
      end
      if (!ok) chk({tag, "_rsp_to"}, 64'(ok), 64'd1);
   endtask

   task automatic take_rsp(input logic [1:0] bitv);
      bus.rsp_ack = bitv;
      tick();
      bus.rsp_ack = 2'b00;
   endtask

   task automatic xact(input string tag, input int idx,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] em);
      int n;
      logic [1:0] oh;
      oh = 2'b01 << idx;
      set_op(idx, a, b);
      bus.req_stb = oh;
      wait_ack(tag, n);
      chk({tag, "_ack"}, 64'(bus.req_ack), 64'(oh));
      tick();
      bus.req_stb = 2'b00;
      wait_rsp(tag, n);
      chk({tag, "_q"}, 64'(bus.rsp_quotient), 64'(eq));
      chk({tag, "_m"}, 64'(bus.rsp_modulo), 64'(em));
      take_rsp(oh);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, bad, seen;
      logic [1:0] g;
      rst              = 1'b1;
      bus.req_stb      = 2'b00;
      bus.rsp_ack      = 2'b00;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      tick();
      tick();
      tick();
      rst = 1'b0;

      chk("rst_req_ack", 64'(bus.req_ack), 64'd0);
      chk("rst_rsp_stb", 64'(bus.rsp_stb), 64'd0);
      chk("rst_div_stb", 64'(bus.div_stb), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_quot", 64'(bus.rsp_quotient), 64'd0);
      chk("rst_dvd", 64'(bus.div_dividend), 64'd0);

      // single request, divider latency 18
      lat = 18;
      set_op(0, 16'd1112, 16'd500);
      bus.req_stb = 2'b01;
      tick();
      chk("t1_req_ack", 64'(bus.req_ack), 64'd1);
      chk("t1_busy", 64'(bus.busy), 64'd1);
      tick();
      bus.req_stb = 2'b00;
      chk("t1_ack_drop", 64'(bus.req_ack), 64'd0);
      chk("t1_div_stb", 64'(bus.div_stb), 64'd1);
      chk("t1_dvd", 64'(bus.div_dividend), 64'd1112);
      chk("t1_dvs", 64'(bus.div_divisor), 64'd500);
      wait_rsp("t1", n);
      chk("t1_lat", 64'(n), 64'd18);
      chk("t1_rsp_stb", 64'(bus.rsp_stb), 64'd1);
      chk("t1_q", 64'(bus.rsp_quotient), 64'd2);
      chk("t1_m", 64'(bus.rsp_modulo), 64'd112);
      chk("t1_err", 64'(bus.rsp_err), 64'd0);
      chk("t1_div_drop", 64'(bus.div_stb), 64'd0);
      tick();
      tick();
      chk("t1_hold_q", 64'(bus.rsp_quotient), 64'd2);
      take_rsp(2'b01);
      chk("t1_rsp_clr", 64'(bus.rsp_stb), 64'd0);
      chk("t1_idle", 64'(bus.busy), 64'd0);

      // contention from reset: grants 0,1,0,1
      do_reset();
      lat = 3;
      set_op(0, 16'd100, 16'd7);
      set_op(1, 16'hFF9C, 16'd7);
      bus.req_stb = 2'b11;
      for (int t = 0; t < 4; t++) begin
         g = 2'b01 << (t % 2);
         wait_ack("ct", n);
         chk("ct_grant", 64'(bus.req_ack), 64'(g));
         tick();
         wait_rsp("ct", n);
         chk("ct_rsp_stb", 64'(bus.rsp_stb), 64'(g));
         chk("ct_q", 64'(bus.rsp_quotient),
             (t % 2 == 1) ? 64'hFFF2 : 64'd14);
         chk("ct_m", 64'(bus.rsp_modulo),
             (t % 2 == 1) ? 64'hFFFE : 64'd2);
         take_rsp(g);
      end
      bus.req_stb = 2'b00;

      // divide by zero on requester 1
      do_reset();
      set_op(1, 16'd55, 16'd0);
      bus.req_stb = 2'b10;
      tick();
      chk("dz_ack", 64'(bus.req_ack), 64'd2);
      tick();
      bus.req_stb = 2'b00;
      chk("dz_rsp_stb", 64'(bus.rsp_stb), 64'd2);
      chk("dz_q", 64'(bus.rsp_quotient), 64'hFFFF);
      chk("dz_m", 64'(bus.rsp_modulo), 64'd55);
      chk("dz_err", 64'(bus.rsp_err), 64'd1);
      chk("dz_no_div", 64'(bus.div_stb), 64'd0);
      take_rsp(2'b10);

      // timeout: divider never acks
      never = 1'b1;
      set_op(0, 16'd1000, 16'd3);
      bus.req_stb = 2'b01;
      tick();
      tick();
      bus.req_stb = 2'b00;
      chk("to_div_stb", 64'(bus.div_stb), 64'd1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!bus.div_stb) break;
         tick();
         n++;
      end
      chk("to_len", 64'(n), 64'd32);
      chk("to_rsp_stb", 64'(bus.rsp_stb), 64'd1);
      chk("to_err", 64'(bus.rsp_err), 64'd1);
      chk("to_q", 64'(bus.rsp_quotient), 64'd0);
      chk("to_m", 64'(bus.rsp_modulo), 64'd0);
      take_rsp(2'b01);

      // ack on the same edge as timeout wins
      never = 1'b0;
      lat   = 32;
      bus.req_stb = 2'b01;
      tick();
      tick();
      bus.req_stb = 2'b00;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!bus.div_stb) break;
         tick();
         n++;
      end
      chk("tw_len", 64'(n), 64'd32);
      chk("tw_err", 64'(bus.rsp_err), 64'd0);
      chk("tw_q", 64'(bus.rsp_quotient), 64'd333);
      chk("tw_m", 64'(bus.rsp_modulo), 64'd1);
      take_rsp(2'b01);

      // response backpressure with a waiting requester
      lat = 2;
      set_op(0, 16'd50, 16'd5);
      bus.req_stb = 2'b01;
      tick();
      tick();
      bus.req_stb = 2'b00;
      wait_rsp("bp", n);
      chk("bp_rsp_stb", 64'(bus.rsp_stb), 64'd1);
      set_op(1, 16'd9, 16'd2);
      bus.req_stb = 2'b10;
      bus.rsp_ack = 2'b10;
      bad  = 0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.rsp_quotient != 16'd10 ||
             bus.rsp_modulo != 16'd0 ||
             bus.rsp_stb != 2'b01) bad++;
         if (bus.req_ack != 2'b00) seen++;
      end
      chk("bp_stable", 64'(bad), 64'd0);
      chk("bp_no_grant", 64'(seen), 64'd0);
      take_rsp(2'b01);
      chk("bp_rsp_clr", 64'(bus.rsp_stb), 64'd0);
      chk("bp_not_yet", 64'(bus.req_ack), 64'd0);
      tick();
      chk("bp_grant1", 64'(bus.req_ack), 64'd2);
      tick();
      bus.req_stb = 2'b00;
      wait_rsp("bp1", n);
      chk("bp1_rsp_stb", 64'(bus.rsp_stb), 64'd2);
      chk("bp1_q", 64'(bus.rsp_quotient), 64'd4);
      chk("bp1_m", 64'(bus.rsp_modulo), 64'd1);
      take_rsp(2'b10);

      // leave last grant on 0, then reset mid-issue
      lat = 1;
      xact("pre", 0, 16'd20, 16'd6, 16'd3, 16'd2);
      never = 1'b1;
      set_op(0, 16'd7, 16'd7);
      bus.req_stb = 2'b01;
      tick();
      tick();
      bus.req_stb = 2'b00;
      tick();
      tick();
      tick();
      chk("mr_in_issue", 64'(bus.div_stb), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_req_ack", 64'(bus.req_ack), 64'd0);
      chk("mr_rsp_stb", 64'(bus.rsp_stb), 64'd0);
      chk("mr_div_stb", 64'(bus.div_stb), 64'd0);
      chk("mr_busy", 64'(bus.busy), 64'd0);
      chk("mr_quot", 64'(bus.rsp_quotient), 64'd0);
      chk("mr_mod", 64'(bus.rsp_modulo), 64'd0);
      chk("mr_dvd", 64'(bus.div_dividend), 64'd0);
      never = 1'b0;
      lat   = 2;
      set_op(0, 16'd8, 16'd2);
      set_op(1, 16'd9, 16'd3);
      bus.req_stb = 2'b11;
      tick();
      chk("mr_first", 64'(bus.req_ack), 64'd1);
      tick();
      bus.req_stb = 2'b10;
      wait_rsp("mr0", n);
      chk("mr0_q", 64'(bus.rsp_quotient), 64'd4);
      take_rsp(2'b01);
      wait_ack("mr1", n);
      chk("mr_second", 64'(bus.req_ack), 64'd2);
      tick();
      bus.req_stb = 2'b00;
      wait_rsp("mr1", n);
      chk("mr1_q", 64'(bus.rsp_quotient), 64'd3);
      take_rsp(2'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
